// File: rtl/transport_tx_scheduler.sv
// Transmit-side packet scheduler: arbitrates control words against audio samples
// and serialises fixed-size packets onto the network byte stream.
module transport_tx_scheduler #(
    parameter int unsigned PACKET_BYTES = 16,
    parameter int unsigned MAX_CTRL_RUN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ctrl_valid,
    input  logic [15:0] ctrl_word,
    output logic        ctrl_ready,
    input  logic [10:0] audio_count,
    output logic        audio_rd_en,
    input  logic [15:0] audio_data,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        pkt_done,
    output logic [1:0]  pkt_type
);

    localparam int unsigned SAMPLES = (PACKET_BYTES - 2) / 2;
    localparam int unsigned CNT_W   = $clog2(PACKET_BYTES + 1);
    localparam int unsigned RUN_W   = $clog2(MAX_CTRL_RUN + 1);

    localparam logic [CNT_W-1:0] SAMPLES_C  = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0] CTRL_PAD_C = CNT_W'(PACKET_BYTES - 3);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [RUN_W-1:0] MAX_RUN_C  = RUN_W'(MAX_CTRL_RUN);
    localparam logic [10:0]      ELIG_C     = 11'(SAMPLES);

    localparam logic [1:0] TYPE_CTRL  = 2'b01;
    localparam logic [1:0] TYPE_AUDIO = 2'b10;
    localparam logic [7:0] HDR_CTRL   = 8'h40;
    localparam logic [7:0] HDR_AUDIO  = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_C_HI,
        S_C_LO,
        S_PAD,
        S_A_RD,
        S_A_CAP,
        S_A_HI,
        S_A_LO,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] pad_cnt_q, pad_cnt_d;
    logic [CNT_W-1:0] samples_left_q, samples_left_d;
    logic [15:0]      word_q, word_d;
    logic [15:0]      sample_q, sample_d;
    logic             ctrl_ready_q, ctrl_ready_d;
    logic [1:0]       pkt_type_q, pkt_type_d;

    logic audio_elig;
    logic ctrl_win;

    assign audio_elig = (audio_count >= ELIG_C);
    // Control is blocked only once its run has starved eligible audio long enough.
    assign ctrl_win   = ctrl_valid && !(audio_elig && (run_cnt_q == MAX_RUN_C));

    assign ctrl_ready = ctrl_ready_q;
    assign pkt_type   = pkt_type_q;

    always_comb begin
        state_d        = state_q;
        run_cnt_d      = run_cnt_q;
        pad_cnt_d      = pad_cnt_q;
        samples_left_d = samples_left_q;
        word_d         = word_q;
        sample_d       = sample_q;
        pkt_type_d     = pkt_type_q;
        ctrl_ready_d   = 1'b0;
        tx_valid       = 1'b0;
        tx_byte        = 8'h00;
        audio_rd_en    = 1'b0;
        pkt_done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (ctrl_win) begin
                        ctrl_ready_d = 1'b1;
                        word_d       = ctrl_word;
                        pkt_type_d   = TYPE_CTRL;
                        state_d      = S_HDR;
                        if (!audio_elig) begin
                            run_cnt_d = '0;
                        end else if (run_cnt_q != MAX_RUN_C) begin
                            run_cnt_d = run_cnt_q + RUN_W'(1);
                        end
                    end else if (audio_elig) begin
                        pkt_type_d     = TYPE_AUDIO;
                        run_cnt_d      = '0;
                        samples_left_d = SAMPLES_C;
                        state_d        = S_HDR;
                    end
                end
            end

            S_HDR: begin
                tx_valid = 1'b1;
                tx_byte  = (pkt_type_q == TYPE_CTRL) ? HDR_CTRL : HDR_AUDIO;
                if (tx_ready) begin
                    state_d = (pkt_type_q == TYPE_CTRL) ? S_C_HI : S_A_RD;
                end
            end

            S_C_HI: begin
                tx_valid = 1'b1;
                tx_byte  = word_q[15:8];
                if (tx_ready) begin
                    state_d = S_C_LO;
                end
            end

            S_C_LO: begin
                tx_valid = 1'b1;
                tx_byte  = word_q[7:0];
                if (tx_ready) begin
                    pad_cnt_d = CTRL_PAD_C;
                    state_d   = S_PAD;
                end
            end

            S_PAD: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    if (pad_cnt_q > CNT_ONE) begin
                        pad_cnt_d = pad_cnt_q - CNT_ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_A_RD: begin
                audio_rd_en = 1'b1;
                state_d     = S_A_CAP;
            end

            S_A_CAP: begin
                sample_d = audio_data;
                state_d  = S_A_HI;
            end

            S_A_HI: begin
                tx_valid = 1'b1;
                tx_byte  = sample_q[15:8];
                if (tx_ready) begin
                    state_d = S_A_LO;
                end
            end

            S_A_LO: begin
                tx_valid = 1'b1;
                tx_byte  = sample_q[7:0];
                if (tx_ready) begin
                    if (samples_left_q > CNT_ONE) begin
                        samples_left_d = samples_left_q - CNT_ONE;
                        state_d        = S_A_RD;
                    end else begin
                        pad_cnt_d = CNT_ONE;
                        state_d   = S_PAD;
                    end
                end
            end

            S_DONE: begin
                pkt_done = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            run_cnt_q      <= '0;
            pad_cnt_q      <= '0;
            samples_left_q <= '0;
            word_q         <= '0;
            sample_q       <= '0;
            ctrl_ready_q   <= 1'b0;
            pkt_type_q     <= '0;
        end else begin
            state_q        <= state_d;
            run_cnt_q      <= run_cnt_d;
            pad_cnt_q      <= pad_cnt_d;
            samples_left_q <= samples_left_d;
            word_q         <= word_d;
            sample_q       <= sample_d;
            ctrl_ready_q   <= ctrl_ready_d;
            pkt_type_q     <= pkt_type_d;
        end
    end

endmodule

// File: doc/transport_tx_scheduler.md
# transport_tx_scheduler

Transmit-side packet scheduler for the transport layer. It arbitrates between a control-word requester and an audio-sample FIFO, and builds fixed-size packets for the network byte stream. Control packets carry header 0x40, one 16-bit word and zero padding. Audio packets carry header 0x80, a run of 16-bit samples (high byte first) and zero padding. The packet format is the one the transport receive path parses.

## Interface
- PACKET_BYTES, 16: packet length in bytes; even, ≥ 4.
- MAX_CTRL_RUN, 4: consecutive control packets allowed while audio is eligible before audio is forced; ≥ 1.
- clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
- enable  in  1  when low, no new packet is granted; a packet in progress still completes.
- ctrl_valid  in  1  control word pending; held until accepted.
- ctrl_word  in  16  control payload.
- ctrl_ready  out  1  one-cycle pulse: ctrl_word captured.
- audio_count  in  11  occupancy of the audio FIFO in samples.
- audio_rd_en  out  1  one-cycle read strobe to the audio FIFO.
- audio_data  in  16  FIFO output, valid the cycle after audio_rd_en.
- tx_byte  out  8  network byte.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  network accepts; a transfer occurs when tx_valid & tx_ready.
- pkt_done  out  1  one-cycle pulse after the last byte of a packet transfers.
- pkt_type  out  2  01 = control, 10 = audio; updated at grant, held until the next grant.

## Operation
- SAMPLES = (PACKET_BYTES-2)/2. With PACKET_BYTES = 16, SAMPLES = 7.
- Audio packet layout: 0x80, SAMPLES×{hi, lo}, one 0x00 pad byte.
- Control packet layout: 0x40, word[15:8], word[7:0], then PACKET_BYTES-3 bytes of 0x00.
- Audio is eligible when audio_count ≥ SAMPLES.
- Arbitration runs only in IDLE, with enable = 1:
  - Control wins if ctrl_valid, unless audio is eligible and run_cnt == MAX_CTRL_RUN.
  - Otherwise audio wins if eligible.
  - Otherwise the block stays in IDLE.
- run_cnt:
  - increments on each control grant while audio is eligible, saturating at MAX_CTRL_RUN;
  - clears on each audio grant, and on any control grant while audio is not eligible.
- On a control grant: ctrl_ready pulses and ctrl_word is latched.
- States:
  - IDLE → HDR on grant.
  - HDR → C_HI (control) or A_RD (audio).
  - C_HI → C_LO → PAD.
  - PAD stays in PAD while pad_cnt > 1; otherwise → DONE.
  - A_RD (audio_rd_en = 1) → A_CAP (capture audio_data) → A_HI → A_LO.
  - A_LO → A_RD while samples_left > 1; otherwise → PAD with pad_cnt = 1.
  - DONE (pkt_done = 1) → IDLE.
- In HDR, C_HI, C_LO, PAD, A_HI and A_LO:
  - tx_valid = 1;
  - the state advances only on tx_ready;
  - tx_byte and tx_valid stay stable until the transfer.
- A_RD, A_CAP, DONE and IDLE drive tx_valid = 0.
- The audio FIFO is never read more than SAMPLES times per packet. Eligibility was checked at grant, so the FIFO never underflows.
- Counters: pad_cnt and samples_left are sized to hold PACKET_BYTES and do not wrap.

## Timing
- Reset values: ctrl_ready 0, audio_rd_en 0, tx_valid 0, tx_byte 0x00, pkt_done 0, pkt_type 00, run_cnt 0, state IDLE.
- Grant to header: grant in cycle N, ctrl_ready pulse in N+1, tx_valid high with 0x40 or 0x80 in N+1.
- With tx_ready held high:
  - a control packet takes 1 + PACKET_BYTES + 1 cycles from grant to DONE;
  - an audio packet takes 2 extra cycles per sample.
- audio_rd_en to capture: exactly 1 cycle.
- ctrl_valid rising while a packet is in progress is serviced at the next IDLE.
- enable falling mid-packet has no effect until IDLE.
- Reset mid-packet:
  - next cycle tx_valid = 0 and state = IDLE;
  - the partial packet is abandoned and not padded;
  - samples already read are discarded;
  - downstream is reset together with this block.

## Test plan
- Single control: ctrl_word = 0xA55A, tx_ready = 1, PACKET_BYTES = 16 → bytes 40 A5 5A followed by thirteen 00; one ctrl_ready pulse; one pkt_done; pkt_type = 01.
- Audio: FIFO preloaded with 0x1122..0x7788 (7 samples) → bytes 80 11 22 … 77 88 00; exactly 7 audio_rd_en pulses; audio_count drops to 0.
- Backpressure: audio packet with tx_ready toggling 1/0 every cycle → byte sequence identical to the previous case; tx_byte stable whenever tx_valid is high and tx_ready is low.
- Fairness: ctrl_valid held high, audio_count = 20, MAX_CTRL_RUN = 4 → packet order C C C C A C C C C A.
- Ineligible audio: audio_count = 6, no control pending → no grant, audio_rd_en never asserted. Raising the count to 7 → audio packet granted on the next cycle.
- Reset after the 5th byte of an audio packet → tx_valid = 0 the next cycle; a fresh control request is granted cleanly afterwards with run_cnt = 0.
